axis_ring_writer: RTL and testbench

- Downstream consumer of the resource-grid subscriber's sample FIFO.
- Drains the AXI-stream of IQ samples and packs two samples per AXI4 beat.
- Writes fixed-length INCR bursts into a DDR ring of NUM_SEGMENTS segments.
- Reports the last completed segment, busy and stall status back to the subscriber.

---
 rtl/ring_writer_pkg.sv | 18 +
 rtl/axis_sample_packer.sv | 71 +++++++
 rtl/axis_ring_writer.sv | 182 ++++++++++++++++++
 tb/tb_axis_ring_writer.sv | 399 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ring_writer_pkg.sv
// Shared types and constants for the AXI-stream to DDR ring writer.
package ring_writer_pkg;

    typedef enum logic [1:0] {
        IDLE,
        AW,
        W,
        B
    } state_t;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

    function automatic int seg_bytes(input int segment_size, input int iq_width);
        return segment_size * iq_width / 8;
    endfunction

endpackage

// File: rtl/axis_sample_packer.sv
// Packs two IQ samples per AXI write beat, holding the output beat until wready.
module axis_sample_packer #(
    parameter int IQ_WIDTH  = 16,
    parameter int BURST_LEN = 8
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  active,
    input  logic [IQ_WIDTH-1:0]   sample_data,
    input  logic                  sample_valid,
    output logic                  sample_ready,
    output logic [2*IQ_WIDTH-1:0] wdata,
    output logic                  wvalid,
    output logic                  wlast,
    input  logic                  wready,
    output logic                  burst_done,
    output logic                  stall
);

    localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);

    logic                pack_phase;
    logic                all_loaded;
    logic [IQ_WIDTH-1:0] low_half;
    logic [BW-1:0]       beat_cnt;
    logic                take;

    // The low half always has room; the completing sample needs the output
    // register free or draining. Once the last beat is loaded, no more samples
    // are taken until the burst is acknowledged.
    assign sample_ready = active && !all_loaded && (!pack_phase || !wvalid || wready);
    assign take         = sample_ready && sample_valid;
    assign burst_done   = wvalid && wready && wlast;
    assign stall        = sample_ready && !sample_valid;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            pack_phase <= 1'b0;
            all_loaded <= 1'b0;
            low_half   <= '0;
            beat_cnt   <= '0;
            wdata      <= '0;
            wvalid     <= 1'b0;
            wlast      <= 1'b0;
        end else begin
            if (wvalid && wready) begin
                wvalid <= 1'b0;
                if (wlast) all_loaded <= 1'b0;
            end
            if (take) begin
                if (!pack_phase) begin
                    low_half   <= sample_data;
                    pack_phase <= 1'b1;
                end else begin
                    wdata      <= {sample_data, low_half};
                    wvalid     <= 1'b1;
                    wlast      <= (beat_cnt == LAST_BEAT);
                    pack_phase <= 1'b0;
                    if (beat_cnt == LAST_BEAT) begin
                        beat_cnt   <= '0;
                        all_loaded <= 1'b1;
                    end else begin
                        beat_cnt <= beat_cnt + BW'(1);
                    end
                end
            end
        end
    end

endmodule

// File: rtl/axis_ring_writer.sv
// Drains the IQ sample stream into fixed-length INCR bursts over a DDR segment ring.
// Optional statistics outputs are enabled with RING_WRITER_STATS_EN.
module axis_ring_writer
    import ring_writer_pkg::*;
#(
    parameter int NUM_SEGMENTS = 10,
    parameter int SEGMENT_SIZE = 240,
    parameter int IQ_WIDTH     = 16,
    parameter int BURST_LEN    = 8,
    parameter int ADDR_WIDTH   = 32
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic [IQ_WIDTH-1:0]           s_axis_tdata,
    input  logic                          s_axis_tvalid,
    output logic                          s_axis_tready,
    input  logic [ADDR_WIDTH-1:0]         base_addr_i,
    input  logic                          enable_i,
    output logic [ADDR_WIDTH-1:0]         m_axi_awaddr,
    output logic [7:0]                    m_axi_awlen,
    output logic [2:0]                    m_axi_awsize,
    output logic [1:0]                    m_axi_awburst,
    output logic                          m_axi_awvalid,
    input  logic                          m_axi_awready,
    output logic [2*IQ_WIDTH-1:0]         m_axi_wdata,
    output logic [2*IQ_WIDTH/8-1:0]       m_axi_wstrb,
    output logic                          m_axi_wlast,
    output logic                          m_axi_wvalid,
    input  logic                          m_axi_wready,
    input  logic [1:0]                    m_axi_bresp,
    input  logic                          m_axi_bvalid,
    output logic                          m_axi_bready,
    output logic [$clog2(NUM_SEGMENTS)-1:0] last_segment_o,
    output logic                          busy_o,
    output logic                          underflow_o,
    output logic                          resp_err_o,
`ifdef RING_WRITER_STATS_EN
    output logic [31:0]                   segment_count_o,
    output logic [31:0]                   stall_count_o,
`endif
    output state_t                        state_o
);

    localparam int SW             = $clog2(NUM_SEGMENTS);
    localparam int BURSTS_PER_SEG = SEGMENT_SIZE / (2 * BURST_LEN);
    localparam int BCW            = (BURSTS_PER_SEG > 1) ? $clog2(BURSTS_PER_SEG) : 1;
    localparam logic [SW-1:0]         LAST_SEG    = SW'(NUM_SEGMENTS - 1);
    localparam logic [BCW-1:0]        LAST_BURST  = BCW'(BURSTS_PER_SEG - 1);
    localparam logic [ADDR_WIDTH-1:0] SEG_BYTES   = ADDR_WIDTH'(seg_bytes(SEGMENT_SIZE, IQ_WIDTH));
    localparam logic [ADDR_WIDTH-1:0] BURST_BYTES = ADDR_WIDTH'(BURST_LEN * 2 * IQ_WIDTH / 8);

    state_t         state;
    logic [SW-1:0]  seg;
    logic [SW-1:0]  seg_next;
    logic [BCW-1:0] burst;
    logic           burst_done;
    logic           stall;
    logic           stall_seen;

    function automatic logic [ADDR_WIDTH-1:0] burst_addr(input logic [ADDR_WIDTH-1:0] base,
                                                         input logic [SW-1:0]         s,
                                                         input logic [BCW-1:0]        b);
        return base + ADDR_WIDTH'(s) * SEG_BYTES + ADDR_WIDTH'(b) * BURST_BYTES;
    endfunction

    assign seg_next      = (seg == LAST_SEG) ? '0 : seg + SW'(1);
    assign busy_o        = (state != IDLE);
    assign state_o       = state;
    assign m_axi_awlen   = 8'(BURST_LEN - 1);
    assign m_axi_awsize  = 3'($clog2(2 * IQ_WIDTH / 8));
    assign m_axi_awburst = BURST_INCR;
    assign m_axi_wstrb   = '1;

    axis_sample_packer #(
        .IQ_WIDTH  (IQ_WIDTH),
        .BURST_LEN (BURST_LEN)
    ) u_packer (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .active       (state == W),
        .sample_data  (s_axis_tdata),
        .sample_valid (s_axis_tvalid),
        .sample_ready (s_axis_tready),
        .wdata        (m_axi_wdata),
        .wvalid       (m_axi_wvalid),
        .wlast        (m_axi_wlast),
        .wready       (m_axi_wready),
        .burst_done   (burst_done),
        .stall        (stall)
    );

    // Every channel transfers on a cycle where valid and ready are both high;
    // a raised valid and its payload stay unchanged until that cycle.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state          <= IDLE;
            seg            <= '0;
            burst          <= '0;
            m_axi_awaddr   <= '0;
            m_axi_awvalid  <= 1'b0;
            m_axi_bready   <= 1'b0;
            last_segment_o <= LAST_SEG;
            resp_err_o     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (enable_i) begin
                        m_axi_awaddr  <= burst_addr(base_addr_i, seg, burst);
                        m_axi_awvalid <= 1'b1;
                        state         <= AW;
                    end
                end
                AW: begin
                    if (m_axi_awready) begin
                        m_axi_awvalid <= 1'b0;
                        state         <= W;
                    end
                end
                W: begin
                    if (burst_done) begin
                        m_axi_bready <= 1'b1;
                        state        <= B;
                    end
                end
                B: begin
                    if (m_axi_bvalid) begin
                        m_axi_bready <= 1'b0;
                        if (m_axi_bresp != RESP_OKAY) resp_err_o <= 1'b1;
                        if (burst == LAST_BURST) begin
                            burst          <= '0;
                            seg            <= seg_next;
                            last_segment_o <= seg;
                            if (enable_i) begin
                                m_axi_awaddr  <= burst_addr(base_addr_i, seg_next, '0);
                                m_axi_awvalid <= 1'b1;
                                state         <= AW;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            burst         <= burst + BCW'(1);
                            m_axi_awaddr  <= burst_addr(base_addr_i, seg, burst + BCW'(1));
                            m_axi_awvalid <= 1'b1;
                            state         <= AW;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // One pulse per stall run; re-armed only once the stream shows valid again.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            underflow_o <= 1'b0;
            stall_seen  <= 1'b0;
        end else begin
            underflow_o <= stall && !stall_seen;
            if (s_axis_tvalid) stall_seen <= 1'b0;
            else if (stall)    stall_seen <= 1'b1;
        end
    end

`ifdef RING_WRITER_STATS_EN
    logic seg_done;
    assign seg_done = (state == B) && m_axi_bvalid && (burst == LAST_BURST);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            segment_count_o <= '0;
            stall_count_o   <= '0;
        end else begin
            if (seg_done && (segment_count_o != '1)) segment_count_o <= segment_count_o + 32'd1;
            if (stall && (stall_count_o != '1))      stall_count_o   <= stall_count_o + 32'd1;
        end
    end
`else
    // Statistics counters are not built; stalls only drive the underflow pulse.
`endif

endmodule

// File: tb/tb_axis_ring_writer.sv
// Randomized scoreboard bench for axis_ring_writer against an arithmetic ring model.
module tb_axis_ring_writer;
    import ring_writer_pkg::*;

    localparam int NSEG  = 10;
    localparam int SEGSZ = 240;
    localparam int IQW   = 16;
    localparam int BL    = 8;
    localparam int BPS   = SEGSZ / (2 * BL);
    localparam logic [31:0] BASE = 32'h1000_0000;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic [15:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic [31:0] base_addr_i;
    logic        enable_i;
    logic [31:0] m_axi_awaddr;
    logic [7:0]  m_axi_awlen;
    logic [2:0]  m_axi_awsize;
    logic [1:0]  m_axi_awburst;
    logic        m_axi_awvalid;
    logic        m_axi_awready;
    logic [31:0] m_axi_wdata;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_wlast;
    logic        m_axi_wvalid;
    logic        m_axi_wready;
    logic [1:0]  m_axi_bresp;
    logic        m_axi_bvalid;
    logic        m_axi_bready;
    logic [3:0]  last_segment_o;
    logic        busy_o;
    logic        underflow_o;
    logic        resp_err_o;
    state_t      state_o;
`ifdef RING_WRITER_STATS_EN
    logic [31:0] segment_count_o;
    logic [31:0] stall_count_o;
`endif

    axis_ring_writer dut (
        .clk_i          (clk_i),
        .reset_i        (reset_i),
        .s_axis_tdata   (s_axis_tdata),
        .s_axis_tvalid  (s_axis_tvalid),
        .s_axis_tready  (s_axis_tready),
        .base_addr_i    (base_addr_i),
        .enable_i       (enable_i),
        .m_axi_awaddr   (m_axi_awaddr),
        .m_axi_awlen    (m_axi_awlen),
        .m_axi_awsize   (m_axi_awsize),
        .m_axi_awburst  (m_axi_awburst),
        .m_axi_awvalid  (m_axi_awvalid),
        .m_axi_awready  (m_axi_awready),
        .m_axi_wdata    (m_axi_wdata),
        .m_axi_wstrb    (m_axi_wstrb),
        .m_axi_wlast    (m_axi_wlast),
        .m_axi_wvalid   (m_axi_wvalid),
        .m_axi_wready   (m_axi_wready),
        .m_axi_bresp    (m_axi_bresp),
        .m_axi_bvalid   (m_axi_bvalid),
        .m_axi_bready   (m_axi_bready),
        .last_segment_o (last_segment_o),
        .busy_o         (busy_o),
        .underflow_o    (underflow_o),
        .resp_err_o     (resp_err_o),
`ifdef RING_WRITER_STATS_EN
        .segment_count_o(segment_count_o),
        .stall_count_o  (stall_count_o),
`endif
        .state_o        (state_o)
    );

    // ---------------- clock / reset ----------------
    initial forever #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard state ----------------
    int checks   = 0;
    int failures = 0;
    logic [31:0] aw_exp_q[$];
    logic [32:0] w_exp_q[$];
    int   burst_idx, b_cnt, uf_cnt, err_burst, seq_cnt;
    logic [3:0] exp_last_seg;
    bit   exp_err, lastseg_chk, rand_mode, wready_low, abort;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Byte address of the idx-th burst since reset: ring of 10 x 480 B, 32 B bursts.
    function automatic logic [31:0] addr_of(input int idx);
        int seg, b;
        seg = (idx / BPS) % NSEG;
        b   = idx % BPS;
        return BASE + 32'(seg * SEGSZ * IQW / 8) + 32'(b * BL * 2 * IQW / 8);
    endfunction

    // ---------------- slave-side ready/response driver ----------------
    initial begin
        m_axi_awready = 1'b0;
        m_axi_wready  = 1'b0;
        m_axi_bvalid  = 1'b0;
        m_axi_bresp   = 2'b00;
        forever begin
            @(posedge clk_i);
            #1;
            if (rand_mode) begin
                m_axi_awready = ($urandom_range(0, 3) != 0);
                m_axi_wready  = ($urandom_range(0, 3) != 0);
                m_axi_bvalid  = ($urandom_range(0, 3) != 0);
            end else begin
                m_axi_awready = 1'b1;
                m_axi_wready  = 1'b1;
                m_axi_bvalid  = 1'b1;
            end
            if (wready_low) m_axi_wready = 1'b0;
            m_axi_bresp = (b_cnt == err_burst) ? 2'b10 : 2'b00;
        end
    end

    // ---------------- monitor ----------------
    logic        aw_pend, w_pend;
    logic [31:0] aw_prev;
    logic [32:0] w_prev;

    always @(negedge clk_i) begin
        if (reset_i) begin
            aw_pend     = 1'b0;
            w_pend      = 1'b0;
            lastseg_chk = 1'b0;
        end else begin
            if (aw_pend) check("aw_hold", {m_axi_awvalid, m_axi_awaddr}, {1'b1, aw_prev});
            if (w_pend)  check("w_hold", {m_axi_wvalid, m_axi_wlast, m_axi_wdata}, {1'b1, w_prev});
            if (lastseg_chk) begin
                check("last_segment", last_segment_o, exp_last_seg);
                check("resp_err", resp_err_o, exp_err);
                lastseg_chk = 1'b0;
            end
            if (m_axi_awvalid && m_axi_awready) begin
                if (aw_exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL aw_unexpected actual=%0h required=none", m_axi_awaddr);
                end else begin
                    check("awaddr", m_axi_awaddr, aw_exp_q.pop_front());
                end
                check("aw_const", {m_axi_awlen, m_axi_awsize, m_axi_awburst}, {8'd7, 3'd2, 2'b01});
            end
            if (m_axi_wvalid && m_axi_wready) begin
                if (w_exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL w_unexpected actual=%0h required=none", m_axi_wdata);
                end else begin
                    check("wbeat", {m_axi_wlast, m_axi_wdata}, w_exp_q.pop_front());
                end
                check("wstrb", m_axi_wstrb, 4'hf);
            end
            if (m_axi_bvalid && m_axi_bready) begin
                b_cnt++;
                if (m_axi_bresp != 2'b00) exp_err = 1'b1;
                if (b_cnt % BPS == 0) exp_last_seg = 4'(((b_cnt / BPS) - 1) % NSEG);
                lastseg_chk = 1'b1;
            end
            if (underflow_o) uf_cnt++;
            aw_pend = m_axi_awvalid && !m_axi_awready;
            aw_prev = m_axi_awaddr;
            w_pend  = m_axi_wvalid && !m_axi_wready;
            w_prev  = {m_axi_wlast, m_axi_wdata};
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        reset_i       = 1'b1;
        enable_i      = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        rand_mode     = 1'b0;
        wready_low    = 1'b0;
        err_burst     = -1;
        aw_exp_q.delete();
        w_exp_q.delete();
        burst_idx    = 0;
        b_cnt        = 0;
        uf_cnt       = 0;
        seq_cnt      = 0;
        exp_last_seg = 4'd9;
        exp_err      = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        reset_i = 1'b0;
    endtask

    task automatic start_run();
        enable_i = 1'b1;
        aw_exp_q.push_back(addr_of(burst_idx));
    endtask

    task automatic stream_burst(input bit seq, input int gap_at, input int gap_len);
        logic [15:0] s, first;
        bit acc;
        int g;
        first = '0;
        for (int i = 0; i < 2 * BL; i++) begin
            if (abort) return;
            if (seq) begin
                seq_cnt++;
                s = 16'(seq_cnt);
            end else begin
                s = 16'($urandom);
            end
            if (i == gap_at) begin
                repeat (gap_len) begin
                    s_axis_tvalid = 1'b0;
                    @(posedge clk_i);
                    #1;
                end
            end else if (rand_mode && $urandom_range(0, 3) == 0) begin
                s_axis_tvalid = 1'b0;
                @(posedge clk_i);
                #1;
            end
            s_axis_tdata  = s;
            s_axis_tvalid = 1'b1;
            acc = 1'b0;
            g   = 0;
            while (!acc && g < 2000) begin
                @(negedge clk_i);
                acc = s_axis_tready;
                @(posedge clk_i);
                #1;
                g++;
            end
            if (!acc) begin
                checks++;
                failures++;
                $display("FAIL tready_timeout actual=0 required=1 burst=%0d sample=%0d", burst_idx, i);
                abort = 1'b1;
                s_axis_tvalid = 1'b0;
                return;
            end
            if (i % 2 == 0) first = s;
            else w_exp_q.push_back({(i == 2 * BL - 1), s, first});
        end
        s_axis_tvalid = 1'b0;
    endtask

    task automatic run_bursts(input int n, input bit seq, input int gap_at, input int gap_len);
        for (int j = 0; j < n; j++) begin
            if (abort) return;
            if (((burst_idx + 1) % BPS) != 0 || enable_i) aw_exp_q.push_back(addr_of(burst_idx + 1));
            stream_burst(seq, gap_at, gap_len);
            burst_idx++;
        end
    endtask

    task automatic drain();
        int g;
        g = 0;
        while ((aw_exp_q.size() != 0 || w_exp_q.size() != 0) && g < 500) begin
            @(negedge clk_i);
            g++;
        end
        check("aw_q_empty", aw_exp_q.size(), 0);
        check("w_q_empty", w_exp_q.size(), 0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int g;
`ifdef RING_WRITER_STATS_EN
        logic [31:0] stall0;
`endif
        abort       = 1'b0;
        base_addr_i = BASE;
        do_reset();

        // Reset state
        @(negedge clk_i);
        check("rst_valids", {m_axi_awvalid, m_axi_wvalid, m_axi_bready, s_axis_tready}, 4'b0000);
        check("rst_last_segment", last_segment_o, 4'd9);
        check("rst_flags", {busy_o, underflow_o, resp_err_o}, 3'b000);
        check("rst_state", state_o, IDLE);
        check("rst_wlast", m_axi_wlast, 1'b0);

        // Full rate across all ten segments and into the wrap
        start_run();
        run_bursts(NSEG * BPS + 1, 1'b0, -1, 0);
        drain();
        check("wrap_last_segment", last_segment_o, 4'd9);
`ifdef RING_WRITER_STATS_EN
        check("segment_count", segment_count_o, 32'd10);
`endif

        // Output hold while wready is low
        do_reset();
        wready_low = 1'b1;
        start_run();
        fork
            run_bursts(1, 1'b1, -1, 0);
            begin
                g = 0;
                @(negedge clk_i);
                while (!m_axi_wvalid && g < 200) begin
                    @(negedge clk_i);
                    g++;
                end
                for (int h = 0; h < 5; h++) begin
                    check("hold_wdata", {m_axi_wvalid, m_axi_wdata}, {1'b1, 32'h0002_0001});
                    if (h >= 2) check("hold_tready", s_axis_tready, 1'b0);
                    @(negedge clk_i);
                end
                wready_low = 1'b0;
            end
        join
        drain();

        // Stream gap after beat 3
        do_reset();
        start_run();
`ifdef RING_WRITER_STATS_EN
        stall0 = stall_count_o;
`endif
        run_bursts(1, 1'b1, 8, 3);
        check("underflow_pulses", uf_cnt, 1);
`ifdef RING_WRITER_STATS_EN
        check("stall_count_delta", stall_count_o - stall0, 32'd3);
`endif
        drain();

        // Error response on burst 4, random handshakes
        do_reset();
        rand_mode = 1'b1;
        err_burst = 4;
        start_run();
        run_bursts(12, 1'b0, -1, 0);
        drain();
        check("resp_err_sticky", resp_err_o, 1'b1);
        do_reset();
        @(negedge clk_i);
        check("resp_err_cleared", resp_err_o, 1'b0);

        // Enable dropped at burst 5 of segment 2
        rand_mode = 1'b1;
        start_run();
        run_bursts(2 * BPS + 5, 1'b0, -1, 0);
        enable_i = 1'b0;
        run_bursts(BPS - 5, 1'b0, -1, 0);
        g = 0;
        while (busy_o && g < 500) begin
            @(negedge clk_i);
            g++;
        end
        check("idle_busy", busy_o, 1'b0);
        check("idle_last_segment", last_segment_o, 4'd2);
        repeat (30) @(negedge clk_i);
        check("idle_no_aw", m_axi_awvalid, 1'b0);
        drain();

        // Reset mid-burst on a later run
        rand_mode  = 1'b0;
        wready_low = 1'b1;
        start_run();
        s_axis_tdata  = 16'h1234;
        s_axis_tvalid = 1'b1;
        g = 0;
        @(negedge clk_i);
        while (!m_axi_wvalid && g < 200) begin
            @(negedge clk_i);
            g++;
        end
        check("pre_reset_wvalid", m_axi_wvalid, 1'b1);
        @(posedge clk_i);
        #1;
        reset_i = 1'b1;
        #1;
        check("async_rst_valids", {m_axi_awvalid, m_axi_wvalid, m_axi_bready, s_axis_tready}, 4'b0000);
        check("async_rst_last_segment", last_segment_o, 4'd9);
        check("async_rst_busy", busy_o, 1'b0);
        do_reset();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
